// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
// Optional mult/div stall input is enabled by HAZARD_MD_STALL_EN in the top.
package hazard_fwd_ctrl_pkg;

  localparam int PIPE_ADDR_W = 5;
  localparam int PIPE_T_W    = 2;

  typedef enum logic [1:0] {
    FSEL_REG = 2'd0,
    FSEL_E   = 2'd1,
    FSEL_M   = 2'd2,
    FSEL_W   = 2'd3
  } fwd_sel_t;

  localparam logic [PIPE_T_W-1:0] TUSE_NEVER = 2'd3;

  typedef struct packed {
    logic [PIPE_ADDR_W-1:0] dst;
    logic [PIPE_T_W-1:0]    tnew;
    logic [PIPE_ADDR_W-1:0] rs;
    logic [PIPE_ADDR_W-1:0] rt;
  } pipe_entry_t;

  function automatic logic [PIPE_T_W-1:0] sat_dec(input logic [PIPE_T_W-1:0] x);
    if (x == {PIPE_T_W{1'b0}}) begin
      return {PIPE_T_W{1'b0}};
    end else begin
      return x - {{(PIPE_T_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_match.sv
// Compares one source register/tuse against one in-flight producer.
// Caller passes the producer's effective tnew as seen from the consumer.
module hazard_match
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int T_W    = PIPE_T_W
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [T_W-1:0]    tuse,
  input  logic [ADDR_W-1:0] dst,
  input  logic [T_W-1:0]    tnew,
  output logic              match,
  output logic              ready,
  output logic              stall_req
);

  // $0 is never a real dependency
  always_comb begin
    match     = (src != {ADDR_W{1'b0}}) && (dst == src);
    ready     = match && (tnew == {T_W{1'b0}});
    stall_req = match && (tnew > tuse);
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding-select generation for the 5-stage pipeline.
// Define HAZARD_MD_STALL_EN to add the mult/div busy stall inputs.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int T_W    = PIPE_T_W
) (
  input  logic              clk,
  input  logic              reset,
`ifdef HAZARD_MD_STALL_EN
  input  logic              md_busy,
  input  logic              d_md_op,
`endif
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [T_W-1:0]    d_rs_tuse,
  input  logic [T_W-1:0]    d_rt_tuse,
  input  logic [ADDR_W-1:0] d_dst,
  input  logic [T_W-1:0]    d_tnew,
  output logic              stall,
  output logic [1:0]        d_rs_fsel,
  output logic [1:0]        d_rt_fsel,
  output logic [1:0]        e_rs_fsel,
  output logic [1:0]        e_rt_fsel,
  output logic              m_rt_fsel
);

  localparam int N_CMP   = 9;
  localparam int C_DRS_E = 0;
  localparam int C_DRS_M = 1;
  localparam int C_DRT_E = 2;
  localparam int C_DRT_M = 3;
  localparam int C_ERS_M = 4;
  localparam int C_ERS_W = 5;
  localparam int C_ERT_M = 6;
  localparam int C_ERT_W = 7;
  localparam int C_MRT_W = 8;

  // M only keeps what its consumers read (dst, tnew, store-data rt); W only its dst
  pipe_entry_t       e_q, e_d;
  logic [ADDR_W-1:0] m_dst_q, m_dst_d;
  logic [T_W-1:0]    m_tnew_q, m_tnew_d;
  logic [ADDR_W-1:0] m_rt_q, m_rt_d;
  logic [ADDR_W-1:0] w_dst_q, w_dst_d;
  logic [T_W-1:0]    m_tnew_eff;

  logic [ADDR_W-1:0] cmp_src  [N_CMP];
  logic [T_W-1:0]    cmp_tuse [N_CMP];
  logic [ADDR_W-1:0] cmp_dst  [N_CMP];
  logic [T_W-1:0]    cmp_tnew [N_CMP];
  logic [N_CMP-1:0]  hit, rdy, req;

  // Route each source/producer pair; non-D consumers never stall, W is always complete
  always_comb begin
    m_tnew_eff = sat_dec(m_tnew_q);
    cmp_src[C_DRS_E] = d_rs;    cmp_tuse[C_DRS_E] = d_rs_tuse;  cmp_dst[C_DRS_E] = e_q.dst;  cmp_tnew[C_DRS_E] = e_q.tnew;
    cmp_src[C_DRS_M] = d_rs;    cmp_tuse[C_DRS_M] = d_rs_tuse;  cmp_dst[C_DRS_M] = m_dst_q;  cmp_tnew[C_DRS_M] = m_tnew_eff;
    cmp_src[C_DRT_E] = d_rt;    cmp_tuse[C_DRT_E] = d_rt_tuse;  cmp_dst[C_DRT_E] = e_q.dst;  cmp_tnew[C_DRT_E] = e_q.tnew;
    cmp_src[C_DRT_M] = d_rt;    cmp_tuse[C_DRT_M] = d_rt_tuse;  cmp_dst[C_DRT_M] = m_dst_q;  cmp_tnew[C_DRT_M] = m_tnew_eff;
    cmp_src[C_ERS_M] = e_q.rs;  cmp_tuse[C_ERS_M] = TUSE_NEVER; cmp_dst[C_ERS_M] = m_dst_q;  cmp_tnew[C_ERS_M] = m_tnew_eff;
    cmp_src[C_ERS_W] = e_q.rs;  cmp_tuse[C_ERS_W] = TUSE_NEVER; cmp_dst[C_ERS_W] = w_dst_q;  cmp_tnew[C_ERS_W] = {T_W{1'b0}};
    cmp_src[C_ERT_M] = e_q.rt;  cmp_tuse[C_ERT_M] = TUSE_NEVER; cmp_dst[C_ERT_M] = m_dst_q;  cmp_tnew[C_ERT_M] = m_tnew_eff;
    cmp_src[C_ERT_W] = e_q.rt;  cmp_tuse[C_ERT_W] = TUSE_NEVER; cmp_dst[C_ERT_W] = w_dst_q;  cmp_tnew[C_ERT_W] = {T_W{1'b0}};
    cmp_src[C_MRT_W] = m_rt_q;  cmp_tuse[C_MRT_W] = TUSE_NEVER; cmp_dst[C_MRT_W] = w_dst_q;  cmp_tnew[C_MRT_W] = {T_W{1'b0}};
  end

  for (genvar gi = 0; gi < N_CMP; gi++) begin : g_match
    hazard_match #(
      .ADDR_W (ADDR_W),
      .T_W    (T_W)
    ) u_match (
      .src       (cmp_src[gi]),
      .tuse      (cmp_tuse[gi]),
      .dst       (cmp_dst[gi]),
      .tnew      (cmp_tnew[gi]),
      .match     (hit[gi]),
      .ready     (rdy[gi]),
      .stall_req (req[gi])
    );
  end

  // Stall and forwarding selects; youngest ready producer wins
  always_comb begin
    stall = |req;
`ifdef HAZARD_MD_STALL_EN
    stall = stall | (md_busy & d_md_op);
`endif

    if (hit[C_DRS_E] && rdy[C_DRS_E]) begin
      d_rs_fsel = FSEL_E;
    end else if (hit[C_DRS_M] && rdy[C_DRS_M]) begin
      d_rs_fsel = FSEL_M;
    end else begin
      d_rs_fsel = FSEL_REG;
    end

    if (hit[C_DRT_E] && rdy[C_DRT_E]) begin
      d_rt_fsel = FSEL_E;
    end else if (hit[C_DRT_M] && rdy[C_DRT_M]) begin
      d_rt_fsel = FSEL_M;
    end else begin
      d_rt_fsel = FSEL_REG;
    end

    if (hit[C_ERS_M] && rdy[C_ERS_M]) begin
      e_rs_fsel = FSEL_M;
    end else if (hit[C_ERS_W] && rdy[C_ERS_W]) begin
      e_rs_fsel = FSEL_W;
    end else begin
      e_rs_fsel = FSEL_REG;
    end

    if (hit[C_ERT_M] && rdy[C_ERT_M]) begin
      e_rt_fsel = FSEL_M;
    end else if (hit[C_ERT_W] && rdy[C_ERT_W]) begin
      e_rt_fsel = FSEL_W;
    end else begin
      e_rt_fsel = FSEL_REG;
    end

    if (hit[C_MRT_W] && rdy[C_MRT_W]) begin
      m_rt_fsel = 1'b1;
    end else begin
      m_rt_fsel = 1'b0;
    end
  end

  // Pipeline advance: age tnew each stage, bubble into E while stalled
  always_comb begin
    w_dst_d  = m_dst_q;
    m_dst_d  = e_q.dst;
    m_tnew_d = sat_dec(e_q.tnew);
    m_rt_d   = e_q.rt;
    if (stall) begin
      e_d = '0;
    end else begin
      e_d = {d_dst, d_tnew, d_rs, d_rt};
    end
  end

  // Tracking state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q      <= '0;
      m_dst_q  <= {ADDR_W{1'b0}};
      m_tnew_q <= {T_W{1'b0}};
      m_rt_q   <= {ADDR_W{1'b0}};
      w_dst_q  <= {ADDR_W{1'b0}};
    end else begin
      e_q      <= e_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      m_rt_q   <= m_rt_d;
      w_dst_q  <= w_dst_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scoreboard bench for hazard_fwd_ctrl; expected outputs are hand-derived per step.
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       stall;
  logic [1:0] d_rs_fsel, d_rt_fsel, e_rs_fsel, e_rt_fsel;
  logic       m_rt_fsel;
`ifdef HAZARD_MD_STALL_EN
  logic       md_busy;
  logic       d_md_op;
`endif

  typedef struct packed {
    logic       stall;
    logic [1:0] drs;
    logic [1:0] drt;
    logic [1:0] ers;
    logic [1:0] ert;
    logic       mrt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  hazard_fwd_ctrl dut (
    .clk       (clk),
    .reset     (reset),
`ifdef HAZARD_MD_STALL_EN
    .md_busy   (md_busy),
    .d_md_op   (d_md_op),
`endif
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_rs_tuse (d_rs_tuse),
    .d_rt_tuse (d_rt_tuse),
    .d_dst     (d_dst),
    .d_tnew    (d_tnew),
    .stall     (stall),
    .d_rs_fsel (d_rs_fsel),
    .d_rt_fsel (d_rt_fsel),
    .e_rs_fsel (e_rs_fsel),
    .e_rt_fsel (e_rt_fsel),
    .m_rt_fsel (m_rt_fsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string fld, input logic [1:0] obs, input logic [1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, expv);
    end
  endtask

  // Drive one D-stage instruction, record the expectation, check mid low phase, then advance.
  task automatic step(input string tag, input logic rst,
                      input int rs, input int rt, input int rs_tu, input int rt_tu,
                      input int dst, input int tnew,
                      input logic x_stall, input int x_drs, input int x_drt,
                      input int x_ers, input int x_ert, input logic x_mrt);
    exp_t e;
    reset     = rst;
    d_rs      = 5'(rs);
    d_rt      = 5'(rt);
    d_rs_tuse = 2'(rs_tu);
    d_rt_tuse = 2'(rt_tu);
    d_dst     = 5'(dst);
    d_tnew    = 2'(tnew);
    e = '{stall: x_stall, drs: 2'(x_drs), drt: 2'(x_drt), ers: 2'(x_ers), ert: 2'(x_ert), mrt: x_mrt};
    exp_q.push_back(e);
    #2;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      cmp(tag, "stall", {1'b0, stall}, {1'b0, e.stall});
      cmp(tag, "d_rs_fsel", d_rs_fsel, e.drs);
      cmp(tag, "d_rt_fsel", d_rt_fsel, e.drt);
      cmp(tag, "e_rs_fsel", e_rs_fsel, e.ers);
      cmp(tag, "e_rt_fsel", e_rt_fsel, e.ert);
      cmp(tag, "m_rt_fsel", {1'b0, m_rt_fsel}, {1'b0, e.mrt});
    end
    @(negedge clk);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
      d_dst = 5'd0; d_tnew = 2'd0;
      @(negedge clk);
    end
  endtask

  initial begin
`ifdef HAZARD_MD_STALL_EN
    md_busy = 1'b0;
    d_md_op = 1'b0;
`endif
    // reset with arbitrary D inputs
    step("rst_hold",  1'b1, 8, 9, 0, 0, 8, 2,   1'b0, 0, 0, 0, 0, 1'b0);
    step("rst_hold2", 1'b1, 8, 8, 0, 1, 9, 3,   1'b0, 0, 0, 0, 0, 1'b0);
    step("rst_first", 1'b0, 8, 9, 0, 0, 8, 2,   1'b0, 0, 0, 0, 0, 1'b0);
    flush(3);

    // load-use: lw $8 then addu reading $8
    step("lu_lw",     1'b0, 29, 0, 1, 3, 8, 2,  1'b0, 0, 0, 0, 0, 1'b0);
    step("lu_stall",  1'b0, 8, 4, 1, 1, 3, 1,   1'b1, 0, 0, 0, 0, 1'b0);
    step("lu_go",     1'b0, 8, 4, 1, 1, 3, 1,   1'b0, 2, 0, 0, 0, 1'b0);
    step("lu_e_w",    1'b0, 0, 0, 3, 3, 0, 0,   1'b0, 0, 0, 3, 0, 1'b0);
    flush(3);

    // ALU chain
    step("alu_add",   1'b0, 1, 2, 1, 1, 9, 1,   1'b0, 0, 0, 0, 0, 1'b0);
    step("alu_sub",   1'b0, 9, 6, 1, 1, 5, 1,   1'b0, 0, 0, 0, 0, 1'b0);
    step("alu_e_m",   1'b0, 0, 0, 3, 3, 0, 0,   1'b0, 0, 0, 2, 0, 1'b0);
    flush(3);

    // branch right after ALU producer
    step("br_add",    1'b0, 1, 2, 1, 1, 10, 1,  1'b0, 0, 0, 0, 0, 1'b0);
    step("br_stall",  1'b0, 10, 0, 0, 0, 0, 0,  1'b1, 0, 0, 0, 0, 1'b0);
    step("br_go",     1'b0, 10, 0, 0, 0, 0, 0,  1'b0, 2, 0, 0, 0, 1'b0);
    flush(3);

    // two writers of $11, younger has tnew=0 in E
    step("pr_w1",     1'b0, 1, 2, 1, 1, 11, 1,  1'b0, 0, 0, 0, 0, 1'b0);
    step("pr_w2",     1'b0, 3, 0, 1, 3, 11, 0,  1'b0, 0, 0, 0, 0, 1'b0);
    step("pr_rd",     1'b0, 11, 11, 1, 2, 13, 1, 1'b0, 1, 1, 0, 0, 1'b0);
    step("pr_e_m",    1'b0, 0, 0, 3, 3, 0, 0,   1'b0, 0, 0, 2, 2, 1'b0);
    flush(3);

    // writers to $0 never create hazards
    step("z_w",       1'b0, 1, 2, 1, 1, 0, 2,   1'b0, 0, 0, 0, 0, 1'b0);
    step("z_rd",      1'b0, 0, 0, 0, 0, 0, 2,   1'b0, 0, 0, 0, 0, 1'b0);
    step("z_rd2",     1'b0, 0, 0, 0, 0, 0, 0,   1'b0, 0, 0, 0, 0, 1'b0);
    flush(3);

    // store data: lw $12 then sw $12
    step("st_lw",     1'b0, 29, 0, 1, 3, 12, 2, 1'b0, 0, 0, 0, 0, 1'b0);
    step("st_sw",     1'b0, 29, 12, 1, 2, 0, 0, 1'b0, 0, 0, 0, 0, 1'b0);
    step("st_e",      1'b0, 0, 0, 3, 3, 0, 0,   1'b0, 0, 0, 0, 2, 1'b0);
    step("st_m_w",    1'b0, 0, 0, 3, 3, 0, 0,   1'b0, 0, 0, 0, 0, 1'b1);
    flush(3);

    // tuse=3 never stalls; then reset during a stall
    step("rs_lw",     1'b0, 29, 0, 1, 3, 8, 2,  1'b0, 0, 0, 0, 0, 1'b0);
    step("rs_never",  1'b0, 8, 0, 3, 3, 0, 0,   1'b0, 0, 0, 0, 0, 1'b0);
    step("rs_lw2",    1'b0, 8, 0, 1, 3, 7, 2,   1'b0, 2, 0, 2, 0, 1'b0);
    step("rs_stall",  1'b0, 7, 0, 0, 3, 2, 1,   1'b1, 0, 0, 3, 0, 1'b0);
    step("rs_reset",  1'b1, 7, 0, 0, 3, 2, 1,   1'b0, 0, 0, 0, 0, 1'b0);
    step("rs_after",  1'b0, 0, 0, 3, 3, 0, 0,   1'b0, 0, 0, 0, 0, 1'b0);

`ifdef HAZARD_MD_STALL_EN
    flush(3);
    md_busy = 1'b1;
    d_md_op = 1'b1;
    step("md_busy1",  1'b0, 0, 0, 3, 3, 0, 0,   1'b1, 0, 0, 0, 0, 1'b0);
    step("md_busy2",  1'b0, 0, 0, 3, 3, 0, 0,   1'b1, 0, 0, 0, 0, 1'b0);
    md_busy = 1'b0;
    step("md_done",   1'b0, 0, 0, 3, 3, 0, 0,   1'b0, 0, 0, 0, 0, 1'b0);
    d_md_op = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
